branch_predictor: RTL and testbench

Fetch-side branch predictor that consumes resolved branch outcomes from the execute-stage branch comparator. It holds a direct-mapped table of 2-bit saturating counters and a branch target buffer (BTB). At fetch, it gives a taken/not-taken prediction and a next PC in the same cycle. When a branch resolves, it trains the tables, detects mispredictions, and issues a registered one-cycle redirect to fetch. It also keeps branch and misprediction statistics.

---
 rtl/branch_predictor.sv | 95 +++++++++
 tb/tb_branch_predictor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter + BTB predictor with registered redirect and statistics
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);
    localparam int ENTRIES  = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]  r_valid;
    logic [1:0]          r_ctr    [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic                r_redirect_valid;
    logic [31:0]         r_redirect_pc;
    logic [31:0]         r_branches;
    logic [31:0]         r_mispredicts;

    logic [INDEX_BITS-1:0] w_fidx, w_uidx;
    logic [TAG_BITS-1:0]   w_ftag, w_utag;
    logic                  w_fhit, w_uhit, w_mispredict, w_unused;
    logic [1:0]            w_uctr, w_ctr_next;
    logic [31:0]           w_correct_pc;

    assign w_fidx       = fetch_pc[INDEX_BITS+1:2];
    assign w_ftag       = fetch_pc[31:INDEX_BITS+2];
    assign w_uidx       = upd_pc[INDEX_BITS+1:2];
    assign w_utag       = upd_pc[31:INDEX_BITS+2];
    assign w_unused     = ^{fetch_pc[1:0], upd_pc[1:0]};
    assign w_fhit       = r_valid[w_fidx] && r_tag[w_fidx] == w_ftag;
    assign w_uhit       = r_valid[w_uidx] && r_tag[w_uidx] == w_utag;
    assign pred_taken   = w_fhit && r_ctr[w_fidx][1];
    assign pred_target  = pred_taken ? r_target[w_fidx] : fetch_pc + 32'd4;
    assign w_uctr       = r_ctr[w_uidx];
    assign w_ctr_next   = upd_taken ? (w_uctr == 2'd3 ? 2'd3 : w_uctr + 2'd1)
                                    : (w_uctr == 2'd0 ? 2'd0 : w_uctr - 2'd1);
    assign w_correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    assign w_mispredict = (upd_taken != upd_pred_taken) || (upd_pred_target != w_correct_pc);

    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign stat_branches    = r_branches;
    assign stat_mispredicts = r_mispredicts;

    // Train counters/BTB on resolved branches; a taken miss allocates a fresh weakly-taken entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_ctr[i]    <= 2'b01;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_next;
                if (upd_taken) r_target[w_uidx] <= upd_target;
            end else if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
                r_ctr[w_uidx]    <= 2'b10;
            end
        end
    end

    // Registered redirect pulse and wrapping branch/mispredict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_branches       <= '0;
            r_mispredicts    <= '0;
        end else begin
            r_redirect_valid <= upd_valid && w_mispredict;
            if (upd_valid && w_mispredict) r_redirect_pc <= w_correct_pc;
            if (upd_valid) r_branches <= r_branches + 32'd1;
            if (upd_valid && w_mispredict) r_mispredicts <= r_mispredicts + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench against a table-level predictor model
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    typedef struct { logic t; logic [31:0] tgt; } pred_e;
    typedef struct { logic rv; logic [31:0] rpc, br, mp; } post_e;
    pred_e pq[$];
    post_e rq[$];

    int n_checks = 0;
    int n_fail = 0;

    bit          m_valid [16];
    int unsigned m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    logic        m_rv = 1'b0;
    logic [31:0] m_rpc = '0, m_br = '0, m_mp = '0;
    bit          known = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic void predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int i;
        i = idx_of(pc);
        t = m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2;
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    pred_e pe;
    post_e re;
    always @(negedge clk) begin
        if (pq.size() > 0) begin
            pe = pq.pop_front();
            chk("pred_taken", {31'b0, pred_taken}, {31'b0, pe.t});
            chk("pred_target", pred_target, pe.tgt);
        end
        if (rq.size() >= 2) begin
            re = rq.pop_front();
            chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, re.rv});
            chk("redirect_pc", redirect_pc, re.rpc);
            chk("stat_branches", stat_branches, re.br);
            chk("stat_mispredicts", stat_mispredicts, re.mp);
        end
    end

    task automatic cy(input logic r, input logic [31:0] f, input logic v, input logic [31:0] p,
                      input logic t, input logic [31:0] g, input logic pt, input logic [31:0] pg);
        pred_e e;
        post_e s;
        logic [31:0] correct;
        int i;
        @(posedge clk);
        #1;
        rst = r; fetch_pc = f; upd_valid = v; upd_pc = p; upd_taken = t;
        upd_target = g; upd_pred_taken = pt; upd_pred_target = pg;
        if (known) begin
            predict(f, e.t, e.tgt);
            pq.push_back(e);
        end
        if (r) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = '0;
            end
            m_rv = 0; m_rpc = '0; m_br = '0; m_mp = '0;
            known = 1;
        end else if (v) begin
            correct = t ? g : p + 32'd4;
            m_br = m_br + 32'd1;
            m_rv = (t != pt) || (pg != correct);
            if (m_rv) begin
                m_mp = m_mp + 32'd1;
                m_rpc = correct;
            end
            i = idx_of(p);
            if (m_valid[i] && m_tag[i] == (p >> 6)) begin
                m_ctr[i] = t ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
                if (t) m_tgt[i] = g;
            end else if (t) begin
                m_valid[i] = 1; m_tag[i] = p >> 6; m_tgt[i] = g; m_ctr[i] = 2;
            end
        end else begin
            m_rv = 0;
        end
        if (known) begin
            s.rv = m_rv; s.rpc = m_rpc; s.br = m_br; s.mp = m_mp;
            rq.push_back(s);
        end
    endtask

    task automatic idle(input logic [31:0] f);
        cy(0, f, 0, 0, 0, 0, 0, 0);
    endtask

    logic        rt, rpt, et;
    logic [31:0] rf, rp, rg, rpg, eg;
    initial begin
        cy(1, 32'h100, 0, 0, 0, 0, 0, 0);
        idle(32'h100);
        cy(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        idle(32'h100);
        idle(32'h100);
        repeat (5) cy(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        repeat (2) cy(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        idle(32'h100);
        cy(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        idle(32'h100);
        repeat (5) cy(0, 32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104);
        idle(32'h100);
        repeat (4) cy(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        cy(0, 32'h140, 1, 32'h140, 1, 32'h200, 0, 32'h144);
        idle(32'h140);
        idle(32'h100);
        cy(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        idle(32'h100);
        cy(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h84);
        idle(32'h100);
        cy(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        cy(1, 32'h100, 1, 32'h100, 1, 32'h300, 0, 32'h104);
        idle(32'h100);
        idle(32'h100);
        for (int n = 0; n < 3000; n++) begin
            rf = 32'h1000 + ($urandom_range(0, 47) << 2);
            rp = 32'h1000 + ($urandom_range(0, 47) << 2);
            rt = 1'($urandom_range(0, 1));
            rg = $urandom & 32'hFFFF_FFFC;
            predict(rp, et, eg);
            if ($urandom_range(0, 3) == 0) begin
                rpt = 1'($urandom_range(0, 1));
                rpg = ($urandom_range(0, 1) == 0) ? rg : rp + 32'd4;
            end else begin
                rpt = et;
                rpg = eg;
            end
            cy(1'($urandom_range(0, 99) == 0), rf, 1'($urandom_range(0, 3) != 0), rp, rt, rg, rpt, rpg);
        end
        idle(32'h100);
        idle(32'h100);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
